// File: rtl/soc_gpio_ctrl.sv
// Memory-mapped 32-bit GPIO controller: output register, synchronized inputs, sticky edge status, level irq.
// Optional input debounce with a programmable prescaler is enabled by defining SOC_GPIO_DEBOUNCE_EN.
module soc_gpio_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        gnt,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic [31:0] gpio_dout,
  input  logic [31:0] gpio_din,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 16;

  localparam logic [2:0] OFF_ODR  = 3'd0;
  localparam logic [2:0] OFF_IDR  = 3'd1;
  localparam logic [2:0] OFF_RIER = 3'd2;
  localparam logic [2:0] OFF_FIER = 3'd3;
  localparam logic [2:0] OFF_ISR  = 3'd4;
  localparam logic [2:0] OFF_PSC  = 3'd5;

  logic [DW-1:0] odr, idr, rier, fier, isr;
  logic [DW-1:0] meta, sync;
  logic [DW-1:0] idr_next_c, rise_c, fall_c, isr_clr_c, isr_next_c, rd_val_c, psc_rd_c;
  logic [2:0]    off_c;
  logic          wr_c, rd_c;
  logic          unused_addr;

  assign gnt         = req;
  assign gpio_dout   = odr;
  assign off_c       = addr[4:2];
  assign wr_c        = req & we;
  assign rd_c        = req & ~we;
  assign unused_addr = ^{addr[31:5], addr[1:0]};

`ifdef SOC_GPIO_DEBOUNCE_EN
  logic [PW-1:0] psc, cnt;
  logic [DW-1:0] cand, same_c;
  logic          tick_c, psc_wr_c;

  assign tick_c   = (cnt == psc);
  assign psc_wr_c = wr_c && (off_c == OFF_PSC);
  assign same_c   = ~(sync ^ cand);
  assign psc_rd_c = DW'(psc);

  // A pin's filtered level only moves when two consecutive ticks sampled the same value.
  assign idr_next_c = tick_c ? ((idr & ~same_c) | (sync & same_c)) : idr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc  <= '0;
      cnt  <= '0;
      cand <= '0;
    end else begin
      if (psc_wr_c) psc <= wdata[PW-1:0];
      if (psc_wr_c || tick_c) cnt <= '0;
      else                    cnt <= cnt + PW'(1);
      if (tick_c) cand <= sync;
    end
  end
`else
  assign psc_rd_c   = '0;
  assign idr_next_c = sync;
`endif

  // Edges are judged against the value IDR is about to take; a new set beats a same-cycle clear.
  assign rise_c     = ~idr & idr_next_c & rier;
  assign fall_c     = idr & ~idr_next_c & fier;
  assign isr_clr_c  = (wr_c && (off_c == OFF_ISR)) ? wdata : '0;
  assign isr_next_c = (isr & ~isr_clr_c) | rise_c | fall_c;

  always_comb begin
    rd_val_c = '0;
    case (off_c)
      OFF_ODR:  rd_val_c = odr;
      OFF_IDR:  rd_val_c = idr;
      OFF_RIER: rd_val_c = rier;
      OFF_FIER: rd_val_c = fier;
      OFF_ISR:  rd_val_c = isr;
      OFF_PSC:  rd_val_c = psc_rd_c;
      default:  rd_val_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      sync   <= '0;
      idr    <= '0;
      isr    <= '0;
      irq    <= 1'b0;
      odr    <= '0;
      rier   <= '0;
      fier   <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      meta   <= gpio_din;
      sync   <= meta;
      idr    <= idr_next_c;
      isr    <= isr_next_c;
      irq    <= |isr_next_c;
      rvalid <= req;
      rdata  <= rd_c ? rd_val_c : '0;
      if (wr_c) begin
        case (off_c)
          OFF_ODR:  odr  <= wdata;
          OFF_RIER: rier <= wdata;
          OFF_FIER: fier <= wdata;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_soc_gpio_ctrl.sv
// Bench for soc_gpio_ctrl: directed table, edge/collision sequences and a random run against a delay-line model.
module tb_soc_gpio_ctrl;

`ifdef SOC_GPIO_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic        gnt, rvalid, irq;
  logic [31:0] addr = '0, wdata = '0, gpio_din = '0;
  logic [31:0] rdata, gpio_dout;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  soc_gpio_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .gpio_dout(gpio_dout),
    .gpio_din(gpio_din), .irq(irq)
  );

  // Reference: filtered input is the pin value seen two edges ago (dq[1] becomes the new IDR).
  logic [31:0] m_odr, m_rier, m_fier, m_isr, m_rdata;
  logic        m_rvalid;
  logic [31:0] dq [3];
  logic [31:0] t_rise, t_fall, t_rv;

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0: return m_odr;
      3'd1: return dq[2];
      3'd2: return m_rier;
      3'd3: return m_fier;
      3'd4: return m_isr;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_odr = '0; m_rier = '0; m_fier = '0; m_isr = '0; m_rdata = '0; m_rvalid = 1'b0;
      dq[0] = '0; dq[1] = '0; dq[2] = '0;
    end else begin
      t_rise = ~dq[2] & dq[1] & m_rier;
      t_fall = dq[2] & ~dq[1] & m_fier;
      t_rv = m_read(addr[4:2]);
      m_rvalid = req;
      m_rdata = (req && !we) ? t_rv : 32'h0;
      if (req && we && addr[4:2] == 3'd4) m_isr = m_isr & ~wdata;
      m_isr = m_isr | t_rise | t_fall;
      if (req && we) begin
        case (addr[4:2])
          3'd0: m_odr = wdata;
          3'd2: m_rier = wdata;
          3'd3: m_fier = wdata;
          default: ;
        endcase
      end
      dq[2] = dq[1]; dq[1] = dq[0]; dq[0] = gpio_din;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else npass++;
  endtask

  task automatic check_model();
    check("gnt", {31'b0, gnt}, {31'b0, req});
    check("m_dout", gpio_dout, m_odr);
    check("m_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
    if (!DB) begin
      check("m_rdata", rdata, m_rdata);
      check("m_irq", {31'b0, irq}, {31'b0, |m_isr});
    end
  endtask

  // One bus cycle driven at the falling edge, observed at the next falling edge.
  task automatic acc(input logic r, input logic w, input logic [2:0] off, input logic [31:0] d);
    req = r; we = w; wdata = d;
    addr = {27'($urandom), off, 2'($urandom)};
    @(negedge clk);
    check_model();
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) acc(1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  off;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 32'h0,          32'hA5A5_0F0F};
    tbl[1]  = '{1'b1, 3'd2, 32'h0000_0001,  32'h0};
    tbl[2]  = '{1'b0, 3'd2, 32'h0,          32'h0000_0001};
    tbl[3]  = '{1'b1, 3'd3, 32'h8000_0000,  32'h0};
    tbl[4]  = '{1'b0, 3'd3, 32'h0,          32'h8000_0000};
    tbl[5]  = '{1'b1, 3'd6, 32'hFFFF_FFFF,  32'h0};
    tbl[6]  = '{1'b0, 3'd6, 32'h0,          32'h0};
    tbl[7]  = '{1'b0, 3'd7, 32'h0,          32'h0};
    tbl[8]  = '{1'b0, 3'd5, 32'h0,          32'h0};
    tbl[9]  = '{1'b0, 3'd1, 32'h0,          32'h0};
    tbl[10] = '{1'b0, 3'd4, 32'h0,          32'h0};
    tbl[11] = '{1'b0, 3'd0, 32'h0,          32'hA5A5_0F0F};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_dout", gpio_dout, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);

    acc(1'b1, 1'b1, 3'd0, 32'hA5A5_0F0F);
    check("odr_pin", gpio_dout, 32'hA5A5_0F0F);
    for (int i = 0; i < 12; i++) begin
      acc(1'b1, tbl[i].w, tbl[i].off, tbl[i].d);
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
      check($sformatf("tbl%0d_rvalid", i), {31'b0, rvalid}, 32'h1);
    end

    // Reset lands while a write response is pending.
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'hFFFF_0000;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_rvalid", {31'b0, rvalid}, 32'h0);
    check("midrst_dout", gpio_dout, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    for (int o = 0; o < 8; o++) begin
      acc(1'b1, 1'b0, 3'(o), 32'h0);
      check($sformatf("postrst_rd%0d", o), rdata, 32'h0);
    end

`ifndef SOC_GPIO_DEBOUNCE_EN
    // Rising edge on pin 0 with its enable set.
    acc(1'b1, 1'b1, 3'd2, 32'h1);
    gpio_din = 32'h1;
    idle(1); check("rise_irq_n0", {31'b0, irq}, 32'h0);
    idle(1); check("rise_irq_n1", {31'b0, irq}, 32'h0);
    idle(1); check("rise_irq_n2", {31'b0, irq}, 32'h1);
    acc(1'b1, 1'b0, 3'd1, 32'h0); check("rise_idr", rdata, 32'h1);
    acc(1'b1, 1'b0, 3'd4, 32'h0); check("rise_isr", rdata, 32'h1);
    acc(1'b1, 1'b1, 3'd4, 32'h1); check("w1c_irq", {31'b0, irq}, 32'h0);
    acc(1'b1, 1'b0, 3'd4, 32'h0); check("w1c_isr", rdata, 32'h0);

    // Falling edges on bits 31 (enabled) and 30 (masked).
    acc(1'b1, 1'b1, 3'd3, 32'h8000_0000);
    gpio_din = 32'hC000_0001;
    idle(3);
    check("fall_pre_irq", {31'b0, irq}, 32'h0);
    gpio_din = 32'h0000_0001;
    idle(3);
    check("fall_irq", {31'b0, irq}, 32'h1);
    acc(1'b1, 1'b0, 3'd4, 32'h0); check("fall_isr", rdata, 32'h8000_0000);
    acc(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF); check("fall_clr_irq", {31'b0, irq}, 32'h0);

    // W1C of bit 0 in the very cycle a new rise on pin 0 is recorded.
    gpio_din = 32'h0;
    idle(3);
    gpio_din = 32'h1;
    idle(2);
    acc(1'b1, 1'b1, 3'd4, 32'h1); check("coll_irq", {31'b0, irq}, 32'h1);
    acc(1'b1, 1'b0, 3'd4, 32'h0); check("coll_isr", rdata, 32'h1);
    acc(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF);
`endif

    // Random traffic with sparse pin toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) gpio_din = gpio_din ^ ($urandom & $urandom & $urandom);
      acc($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom));
    end

`ifdef SOC_GPIO_DEBOUNCE_EN
    // Prescaler of 3 gives a tick every 4 cycles.
    acc(1'b1, 1'b1, 3'd5, 32'h0000_0003);
    gpio_din = 32'h0;
    idle(24);
    acc(1'b1, 1'b0, 3'd5, 32'h0); check("psc_rd", rdata, 32'h3);
    acc(1'b1, 1'b0, 3'd1, 32'h0); check("db_idr_zero", rdata, 32'h0);
    gpio_din = 32'h4;
    idle(2);
    gpio_din = 32'h0;
    idle(16);
    acc(1'b1, 1'b0, 3'd1, 32'h0); check("db_glitch", rdata, 32'h0);
    gpio_din = 32'h4;
    idle(14);
    acc(1'b1, 1'b0, 3'd1, 32'h0); check("db_stable", rdata, 32'h4);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
